// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared SRAM geometry and address type for the SRAM-backed FIFO controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sram_fifo_ctrl_pkg;

  localparam int SRAM_ADDR_W = 6;
  localparam int SRAM_DATA_W = 64;
  localparam int SRAM_DEPTH  = 64;
  localparam int SRAM_RD_LAT = 1;

  typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;

endpackage

// File: rtl/sram_fifo_outbuf.sv
// Two-entry register FIFO that holds words returned by the SRAM read port.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the controller never pushes into a full buffer.
module sram_fifo_outbuf #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        cnt
);

  logic [DATA_W-1:0] mem [2];
  logic              head;
  logic              wr_idx;

  // With at most two entries the tail slot is the head slot when empty, the other one otherwise.
  assign wr_idx    = head ^ cnt[0];
  assign head_data = mem[head];

  // Head index and occupancy; clear drops everything including a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= 1'b0;
      cnt  <= 2'd0;
    end else if (clear) begin
      head <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (pop) begin
        head <= ~head;
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload storage needs no reset; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Turns an external 1R1W synchronous SRAM plus a 2-entry register buffer into a valid/ready FIFO.
// Latency: enqueue into an empty FIFO in cycle T gives deq_valid in T+3; 1 enq + 1 deq per cycle sustained.
// Backpressure: enq_ready drops only when the SRAM holds DEPTH words; reads stop when the buffer would overflow.
module sram_fifo_ctrl
  import sram_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int DEPTH  = SRAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [DATA_W-1:0] enq_data,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [DATA_W-1:0] deq_data,
  output logic [ADDR_W:0]   count,
  output logic              sram_write_en,
  output logic [ADDR_W-1:0] sram_write_addr,
  output logic [DATA_W-1:0] sram_write_data,
  output logic              sram_read_en,
  output logic [ADDR_W-1:0] sram_read_addr,
  input  logic [DATA_W-1:0] sram_read_data
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   sram_cnt;
  logic              inflight;
  logic [1:0]        ob_cnt;
  logic              ob_push;
  logic              enq_fire;
  logic              deq_fire;
  logic              issue;
  logic [2:0]        ob_occ;
  logic [2:0]        ob_limit;

  // Handshakes and read issue. Issue looks only at the registered sram_cnt, so a word
  // written this cycle cannot be read until next cycle and the ports never collide.
  always_comb begin
    enq_ready = (sram_cnt != (ADDR_W+1)'(DEPTH));
    deq_valid = (ob_cnt != 2'd0);
    enq_fire  = enq_valid & enq_ready & ~clear;
    deq_fire  = deq_valid & deq_ready & ~clear;
    ob_occ    = {1'b0, ob_cnt} + {2'b00, inflight};
    ob_limit  = 3'd2 + {2'b00, deq_fire};
    issue     = ~clear & (sram_cnt != '0) & (ob_occ < ob_limit);
  end

  assign sram_write_en   = enq_fire;
  assign sram_write_addr = wr_ptr;
  assign sram_write_data = enq_data;
  assign sram_read_en    = issue;
  assign sram_read_addr  = rd_ptr;

  // Read data from last cycle's issue lands in the buffer unless a flush is under way.
  assign ob_push = inflight & ~clear;

  assign count = sram_cnt + (ADDR_W+1)'(inflight) + (ADDR_W+1)'(ob_cnt);

  // Pointers, SRAM occupancy and the in-flight flag; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sram_cnt <= '0;
      inflight <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sram_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      if (enq_fire) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      sram_cnt <= sram_cnt + (ADDR_W+1)'(enq_fire) - (ADDR_W+1)'(issue);
      inflight <= issue;
    end
  end

  sram_fifo_outbuf #(
    .DATA_W (DATA_W)
  ) u_outbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (ob_push),
    .push_data (sram_read_data),
    .pop       (deq_fire),
    .head_data (deq_data),
    .cnt       (ob_cnt)
  );

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- FIFO controller that turns the 64x64 1R1W SRAM (synchronous read, 1-cycle latency, shared clock) into a 64-bit valid/ready queue.
- Sequences the SRAM write and read ports and owns the pointers and occupancy.
- A 2-entry output register buffer gives full 1/cycle throughput across the SRAM read latency.
- Sits between a producer and a consumer; the SRAM is instantiated alongside the controller, not inside it.

Parameters:
- ADDR_W, 6, SRAM address width.
- DATA_W, 64, entry width.
- DEPTH, 64, SRAM entries; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock; also drives both SRAM ports.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; highest priority.
- enq_valid  in  1  producer has data.
- enq_ready  out  1  controller accepts data.
- enq_data  in  DATA_W  enqueue payload.
- deq_valid  out  1  head entry valid.
- deq_ready  in  1  consumer takes head.
- deq_data  out  DATA_W  head payload.
- count  out  ADDR_W+1  total entries held: SRAM + in-flight + buffer (0..DEPTH+2).
- sram_write_en  out  1  SRAM write strobe.
- sram_write_addr  out  ADDR_W  equals wr_ptr.
- sram_write_data  out  DATA_W  equals enq_data.
- sram_read_en  out  1  SRAM read strobe.
- sram_read_addr  out  ADDR_W  equals rd_ptr.
- sram_read_data  in  DATA_W  valid in the cycle after sram_read_en.

Behaviour:
- State registers:
  - wr_ptr, rd_ptr: ADDR_W each.
  - sram_cnt: ADDR_W+1, range 0..DEPTH.
  - inflight: 1 bit.
  - ob: 2-entry register FIFO with ob_cnt (0..2) and head index.
- Reset (rst_n=0, asynchronous): all state 0. Outputs enq_ready=1, deq_valid=0, count=0, sram_write_en=0, sram_read_en=0. SRAM contents are don't-care.
- Reset or clear mid-operation: in-flight read data is discarded and is not captured the next cycle.
- enq_fire = enq_valid & enq_ready, where enq_ready = (sram_cnt != DEPTH).
  - On enq_fire: sram_write_en=1 at wr_ptr; wr_ptr increments, wrapping 63->0.
- deq_fire = deq_valid & deq_ready, where deq_valid = (ob_cnt != 0) and deq_data = ob head.
  - On deq_fire the head pops.
- Read issue: issue = (sram_cnt != 0) & (ob_cnt + inflight - deq_fire < 2).
  - issue drives sram_read_en; rd_ptr increments (wrapping) and inflight is set to 1.
  - deq_ready therefore reaches sram_read_en combinationally; this path is accepted.
- Capture: when inflight=1, sram_read_data is pushed into ob at the end of that cycle. inflight clears unless a new issue occurs in the same cycle.
- sram_cnt next = sram_cnt + enq_fire - issue.
  - Issue uses the registered sram_cnt, so a word written in cycle T is read no earlier than T+1.
  - The SRAM therefore never sees a read and a write to the same address in the same cycle. This is a required invariant.
- Simultaneous enq_fire and issue while full (sram_cnt=DEPTH): enq_ready is still 0 that cycle; no bypass.
- Latency:
  - Enqueue into an empty FIFO at cycle T: read at T+1, capture at end of T+2, deq_valid=1 at T+3.
  - Sustained rate is 1 enq + 1 deq per cycle once primed.
- count = sram_cnt + inflight + ob_cnt, combinational from registers.
- Capacity is DEPTH+2 (66). enq_ready depends only on sram_cnt.
- clear=1: all pointers and counts are zeroed and no SRAM strobes are asserted that cycle. enq/deq fire are ignored.
- deq_data is don't-care when deq_valid=0. deq_valid does not depend on enq_valid in the same cycle.

Decomposition:
- Shared package holds: SRAM_ADDR_W=6, SRAM_DATA_W=64, SRAM_DEPTH=64, SRAM_RD_LAT=1, and the typedef sram_addr_t.
- One natural sub-module: sram_fifo_outbuf, the 2-entry register FIFO with push/pop and head output.
- Pointer/count logic stays in the top level.

Test Plan:
- Empty reset: rst_n low then high. Expect count=0, enq_ready=1, deq_valid=0, no SRAM strobes.
- Single word: enq 0xDEADBEEF_00000001 at T. Expect sram_write_en at T addr 0, sram_read_en at T+1 addr 0, deq_valid at T+3 with that data; count goes 1,1,1,1 then 0 after deq.
- Fill: 70 enqueues with deq_ready=0.
  - Expect 66 accepted (values 0..65) and enq_ready=0 once sram_cnt=64, count=66.
  - Then drain and check in-order data 0..65 with pointer wrap.
- Streaming: enq_valid=deq_ready=1 for 200 cycles. After a 3-cycle prime, expect exactly one deq per cycle, in-order data, and count steady at 3.
- Collision check: assertion that sram_read_en & sram_write_en & (sram_read_addr == sram_write_addr) never holds under random valid/ready toggling for 10k cycles, with a scoreboard match.
- Mid-operation reset or clear: with count=10 and a read in flight, assert clear (and separately rst_n=0). Expect count=0 and deq_valid=0 next cycle, and the stale read_data is not captured.
